// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer
// Serial-DAC front end. Captures a frame of CHANNELS parallel samples into a
// pending buffer. When the serializer is idle it moves that frame into per-lane
// shift registers and shifts every lane out MSB-first on one shared DAC clock.
// After the last bit it raises chip select and pulses the latch strobe.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous, active-high reset
//   sample_i       frame input; channel c is at [c*SAMPLE_W +: SAMPLE_W]
//   sample_valid_i one-cycle strobe that captures sample_i into the pending buffer
//   invert_i       shift out (2^SAMPLE_W-1)-x instead of x (sampled at load)
//   mute_i         per-channel force to midscale (sampled at load)
//   dac_clk_o      shared DAC bit clock
//   dac_dat_o      per-channel serial data, changes only on the falling DAC clock
//   dac_csb_o      chip select, active low
//   dac_leb_o      latch enable, active low
//   busy_o         a frame is in flight
//   frame_done_o   one-cycle pulse at the end of a frame
//   overrun_o      one-cycle pulse when a pending frame is overwritten
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a pending frame; loads the shifter when one exists
// SHIFT_LO | DAC clock low for CLK_DIV cycles; data already on the lanes
// SHIFT_HI | DAC clock high for CLK_DIV cycles; DAC samples on this rise
// LATCH    | chip select released, latch strobe low for CLK_DIV cycles

module dac_frame_serializer #(
  parameter int CHANNELS = 3,
  parameter int SAMPLE_W = 12,
  parameter int CLK_DIV  = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_i,
  input  logic                         sample_valid_i,
  input  logic                         invert_i,
  input  logic [CHANNELS-1:0]          mute_i,
  output logic                         dac_clk_o,
  output logic [CHANNELS-1:0]          dac_dat_o,
  output logic                         dac_csb_o,
  output logic                         dac_leb_o,
  output logic                         busy_o,
  output logic                         frame_done_o,
  output logic                         overrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(SAMPLE_W);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(SAMPLE_W - 1);
  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT_LO = 2'd1;
  localparam logic [1:0] ST_SHIFT_HI = 2'd2;
  localparam logic [1:0] ST_LATCH    = 2'd3;

  logic [1:0]                         state;
  logic [DIV_W-1:0]                   div_cnt;
  logic [BIT_W-1:0]                   bit_cnt;
  logic [CHANNELS*SAMPLE_W-1:0]       pending;
  logic                               pending_flag;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  shift_reg;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  load_val;
  logic [CHANNELS-1:0][SAMPLE_W-1:0]  shift_next;
  logic [CHANNELS-1:0]                load_msb;
  logic [CHANNELS-1:0]                next_msb;
  logic                               load;
  logic                               div_tc;

  assign load   = (state == ST_IDLE) && pending_flag;
  assign div_tc = (div_cnt == '0);

  // Mute wins over invert. Inversion of an unsigned code is the bitwise complement.
  always_comb begin
    load_val   = '0;
    shift_next = '0;
    load_msb   = '0;
    next_msb   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mute_i[c])
        load_val[c] = MIDSCALE;
      else if (invert_i)
        load_val[c] = ~pending[c*SAMPLE_W +: SAMPLE_W];
      else
        load_val[c] = pending[c*SAMPLE_W +: SAMPLE_W];
      load_msb[c]   = load_val[c][SAMPLE_W-1];
      shift_next[c] = {shift_reg[c][SAMPLE_W-2:0], 1'b0};
      next_msb[c]   = shift_reg[c][SAMPLE_W-2];
    end
  end

  // A valid on the load edge refills the buffer the shifter is emptying, so it
  // is not an overrun.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending      <= '0;
      pending_flag <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= sample_valid_i && pending_flag && !load;
      if (sample_valid_i) begin
        pending      <= sample_i;
        pending_flag <= 1'b1;
      end else if (load) begin
        pending_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      dac_clk_o    <= 1'b0;
      dac_dat_o    <= '0;
      dac_csb_o    <= 1'b1;
      dac_leb_o    <= 1'b1;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pending_flag) begin
            shift_reg <= load_val;
            dac_dat_o <= load_msb;
            dac_csb_o <= 1'b0;
            busy_o    <= 1'b1;
            bit_cnt   <= '0;
            div_cnt   <= DIV_LAST;
            state     <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (div_tc) begin
            dac_clk_o <= 1'b1;
            div_cnt   <= DIV_LAST;
            state     <= ST_SHIFT_HI;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_SHIFT_HI: begin
          if (div_tc) begin
            dac_clk_o <= 1'b0;
            div_cnt   <= DIV_LAST;
            if (bit_cnt == BIT_LAST) begin
              dac_csb_o <= 1'b1;
              dac_leb_o <= 1'b0;
              state     <= ST_LATCH;
            end else begin
              // New data goes out together with the falling DAC clock.
              shift_reg <= shift_next;
              dac_dat_o <= next_msb;
              bit_cnt   <= bit_cnt + 1'b1;
              state     <= ST_SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        ST_LATCH: begin
          if (div_tc) begin
            dac_leb_o    <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// Self-checking bench for dac_frame_serializer. It uses a default instance
// (3 x 12 bit, CLK_DIV=2) and a narrow instance (1 x 16 bit, CLK_DIV=1).
// Negedge monitors rebuild each emitted frame from the pins: bits taken on the
// rising DAC clock, chip-select and latch-low durations, and the cycle of
// frame_done. The initial block compares these against values the bench
// computes itself from the sample, invert and mute settings.

module tb_dac_frame_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [35:0] sample_i = '0;
  logic        sample_valid_i = 1'b0;
  logic        invert_i = 1'b0;
  logic [2:0]  mute_i = '0;
  logic        dac_clk_o, dac_csb_o, dac_leb_o, busy_o, frame_done_o, overrun_o;
  logic [2:0]  dac_dat_o;

  logic [15:0] sample1 = '0;
  logic        valid1 = 1'b0;
  logic        invert1 = 1'b0;
  logic [0:0]  mute1 = '0;
  logic        dac_clk1, dac_csb1, dac_leb1, busy1, done1, overrun1;
  logic [0:0]  dac_dat1;

  dac_frame_serializer dut (
    .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .invert_i(invert_i), .mute_i(mute_i), .dac_clk_o(dac_clk_o), .dac_dat_o(dac_dat_o),
    .dac_csb_o(dac_csb_o), .dac_leb_o(dac_leb_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .overrun_o(overrun_o)
  );

  dac_frame_serializer #(.CHANNELS(1), .SAMPLE_W(16), .CLK_DIV(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample1), .sample_valid_i(valid1),
    .invert_i(invert1), .mute_i(mute1), .dac_clk_o(dac_clk1), .dac_dat_o(dac_dat1),
    .dac_csb_o(dac_csb1), .dac_leb_o(dac_leb1), .busy_o(busy1),
    .frame_done_o(done1), .overrun_o(overrun1)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [2:0][11:0] lanes;
    int nbits;
    int csb;
    int leb;
    int cyc;
  } frame_t;

  typedef struct {
    logic [15:0] word;
    int nbits;
    int csb;
    int leb;
    int cyc;
  } frame1_t;

  frame_t  frames[$];
  frame1_t frames1[$];

  logic [2:0][11:0] acc;
  int nbits_m, csb_m, leb_m, ovr_cnt, dat_viol, both_viol;
  logic prev_clk;
  logic [2:0] prev_dat;

  logic [15:0] acc1;
  int nbits1, csb1_m, leb1_m, dat_viol1, both_viol1;
  logic prev_clk1;
  logic [0:0] prev_dat1;

  initial begin
    ovr_cnt = 0; dat_viol = 0; both_viol = 0; dat_viol1 = 0; both_viol1 = 0;
  end

  always @(negedge clk_i) begin
    frame_t r;
    if (rst_i) begin
      acc = '0; nbits_m = 0; csb_m = 0; leb_m = 0;
    end else begin
      if (dac_clk_o && !prev_clk) begin
        for (int c = 0; c < 3; c++) acc[c] = {acc[c][10:0], dac_dat_o[c]};
        nbits_m++;
      end
      if (dac_clk_o && (dac_dat_o !== prev_dat)) dat_viol++;
      if (!dac_csb_o && !dac_leb_o) both_viol++;
      if (!dac_csb_o) csb_m++;
      if (!dac_leb_o) leb_m++;
      if (overrun_o) ovr_cnt++;
      if (frame_done_o) begin
        r.lanes = acc; r.nbits = nbits_m; r.csb = csb_m; r.leb = leb_m; r.cyc = cyc;
        frames.push_back(r);
        acc = '0; nbits_m = 0; csb_m = 0; leb_m = 0;
      end
    end
    prev_clk = dac_clk_o;
    prev_dat = dac_dat_o;
  end

  always @(negedge clk_i) begin
    frame1_t r;
    if (rst_i) begin
      acc1 = '0; nbits1 = 0; csb1_m = 0; leb1_m = 0;
    end else begin
      if (dac_clk1 && !prev_clk1) begin
        acc1 = {acc1[14:0], dac_dat1[0]};
        nbits1++;
      end
      if (dac_clk1 && (dac_dat1 !== prev_dat1)) dat_viol1++;
      if (!dac_csb1 && !dac_leb1) both_viol1++;
      if (!dac_csb1) csb1_m++;
      if (!dac_leb1) leb1_m++;
      if (done1) begin
        r.word = acc1; r.nbits = nbits1; r.csb = csb1_m; r.leb = leb1_m; r.cyc = cyc;
        frames1.push_back(r);
        acc1 = '0; nbits1 = 0; csb1_m = 0; leb1_m = 0;
      end
    end
    prev_clk1 = dac_clk1;
    prev_dat1 = dac_dat1;
  end

  int n_assert = 0;
  int n_fail = 0;
  int last_valid_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [35:0] s);
    sample_i = s;
    sample_valid_i = 1'b1;
    tick();
    last_valid_cyc = cyc;
    sample_valid_i = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("frame_arrival", 32'(frames.size() >= n), 32'(1));
  endtask

  // Value the DAC is expected to receive for one channel.
  function automatic logic [11:0] expect_code(input logic [11:0] x, input bit inv, input bit m);
    if (m) return 12'd2048;
    if (inv) return 12'(4095 - int'(x));
    return x;
  endfunction

  task automatic check_frame(input string tag, input int idx, input logic [35:0] s,
                             input bit inv, input logic [2:0] m);
    if (idx >= frames.size()) begin
      chk({tag, "_missing"}, 32'(frames.size()), 32'(idx + 1));
      return;
    end
    for (int c = 0; c < 3; c++)
      chk($sformatf("%s_lane%0d", tag, c), 32'(frames[idx].lanes[c]),
          32'(expect_code(s[c*12 +: 12], inv, m[c])));
    chk({tag, "_bits"}, 32'(frames[idx].nbits), 32'(12));
    chk({tag, "_csb_len"}, 32'(frames[idx].csb), 32'(48));
    chk({tag, "_leb_len"}, 32'(frames[idx].leb), 32'(2));
  endtask

  initial begin
    logic [35:0] s, sa, sb, sc;
    bit inv;
    logic [2:0] m;
    int base, ovr0, vd, k;

    // reset values
    rst_i = 1'b1;
    idle(2);
    chk("rst_clk", 32'(dac_clk_o), 32'(0));
    chk("rst_dat", 32'(dac_dat_o), 32'(0));
    chk("rst_csb", 32'(dac_csb_o), 32'(1));
    chk("rst_leb", 32'(dac_leb_o), 32'(1));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_done", 32'(frame_done_o), 32'(0));
    chk("rst_overrun", 32'(overrun_o), 32'(0));
    rst_i = 1'b0;
    idle(3);

    // directed pattern
    s = {12'h000, 12'hFFF, 12'hA5C};
    send(s);
    tick();
    chk("latency_csb_low", 32'(dac_csb_o), 32'(0));
    chk("latency_busy", 32'(busy_o), 32'(1));
    wait_frames(1, 200);
    check_frame("basic", 0, s, 1'b0, 3'b000);
    if (frames.size() >= 1)
      chk("basic_done_cycle", 32'(frames[0].cyc - last_valid_cyc), 32'(51));
    idle(3);

    // invert plus mute
    s = {12'($urandom()), 12'h123, 12'h001};
    invert_i = 1'b1;
    mute_i = 3'b010;
    send(s);
    wait_frames(2, 200);
    check_frame("inv_mute", 1, s, 1'b1, 3'b010);
    idle(3);

    // random frames, one at a time
    for (int i = 0; i < 4; i++) begin
      s = 36'({$urandom(), $urandom()});
      inv = 1'($urandom_range(0, 1));
      m = 3'($urandom_range(0, 7));
      invert_i = inv;
      mute_i = m;
      base = frames.size();
      send(s);
      wait_frames(base + 1, 200);
      check_frame($sformatf("rand%0d", i), base, s, inv, m);
      idle(2);
    end
    invert_i = 1'b0;
    mute_i = '0;
    chk("no_overrun_yet", 32'(ovr_cnt), 32'(0));

    // overrun: second valid lands in empty pending, third overwrites it
    base = frames.size();
    ovr0 = ovr_cnt;
    sa = 36'({$urandom(), $urandom()});
    sb = 36'({$urandom(), $urandom()});
    sc = 36'({$urandom(), $urandom()});
    send(sa);
    idle(9);
    send(sb);
    idle(4);
    send(sc);
    wait_frames(base + 2, 300);
    check_frame("ovr_first", base, sa, 1'b0, 3'b000);
    check_frame("ovr_newest", base + 1, sc, 1'b0, 3'b000);
    if (frames.size() >= base + 2)
      chk("ovr_spacing", 32'(frames[base+1].cyc - frames[base].cyc), 32'(51));
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'(1));
    idle(80);
    chk("ovr_no_extra_frame", 32'(frames.size()), 32'(base + 2));

    // valid on the exact load edge of the previous frame
    base = frames.size();
    ovr0 = ovr_cnt;
    sa = 36'({$urandom(), $urandom()});
    sb = 36'({$urandom(), $urandom()});
    send(sa);
    vd = last_valid_cyc;
    send(sb);
    wait_frames(base + 2, 300);
    check_frame("simul_a", base, sa, 1'b0, 3'b000);
    check_frame("simul_b", base + 1, sb, 1'b0, 3'b000);
    if (frames.size() >= base + 2) begin
      chk("simul_first_done", 32'(frames[base].cyc - vd), 32'(51));
      chk("simul_spacing", 32'(frames[base+1].cyc - frames[base].cyc), 32'(51));
    end
    chk("simul_no_overrun", 32'(ovr_cnt - ovr0), 32'(0));
    idle(3);

    // reset mid-frame, with another frame pending
    base = frames.size();
    send(36'({$urandom(), $urandom()}));
    idle(20);
    send(36'({$urandom(), $urandom()}));
    idle(2);
    chk("pre_rst_busy", 32'(busy_o), 32'(1));
    rst_i = 1'b1;
    tick();
    chk("midrst_csb", 32'(dac_csb_o), 32'(1));
    chk("midrst_leb", 32'(dac_leb_o), 32'(1));
    chk("midrst_clk", 32'(dac_clk_o), 32'(0));
    chk("midrst_busy", 32'(busy_o), 32'(0));
    rst_i = 1'b0;
    k = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (frame_done_o || busy_o) k++;
    end
    chk("midrst_quiet", 32'(k), 32'(0));
    chk("midrst_no_frame", 32'(frames.size()), 32'(base));
    s = 36'({$urandom(), $urandom()});
    send(s);
    wait_frames(base + 1, 200);
    check_frame("post_rst", base, s, 1'b0, 3'b000);
    if (frames.size() >= base + 1)
      chk("post_rst_done_cycle", 32'(frames[base].cyc - last_valid_cyc), 32'(51));

    // single 16-bit lane, CLK_DIV=1
    sample1 = 16'($urandom());
    valid1 = 1'b1;
    tick();
    vd = cyc;
    valid1 = 1'b0;
    k = 0;
    while (frames1.size() < 1 && k < 200) begin
      tick();
      k++;
    end
    chk("narrow_arrival", 32'(frames1.size()), 32'(1));
    if (frames1.size() >= 1) begin
      chk("narrow_word", 32'(frames1[0].word), 32'(sample1));
      chk("narrow_bits", 32'(frames1[0].nbits), 32'(16));
      chk("narrow_csb_len", 32'(frames1[0].csb), 32'(32));
      chk("narrow_leb_len", 32'(frames1[0].leb), 32'(1));
      chk("narrow_done_cycle", 32'(frames1[0].cyc - vd), 32'(34));
    end
    idle(3);

    chk("dat_stable_on_rise", 32'(dat_viol), 32'(0));
    chk("csb_leb_exclusive", 32'(both_viol), 32'(0));
    chk("narrow_dat_stable", 32'(dat_viol1), 32'(0));
    chk("narrow_csb_leb_exclusive", 32'(both_viol1), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_frame_serializer.md
# dac_frame_serializer

Parametrised serial-DAC front end for the audio path: accepts one frame of CHANNELS parallel samples, double-buffers it, and shifts all channels out simultaneously MSB-first on a shared DAC clock with per-channel data lanes, chip select and latch strobe. Successor to the fixed 2-lane, 12-bit DAC driver inside the SID core; adds channel/width/rate parameters, a pending-frame buffer with overrun reporting, per-channel mute and optional inversion. Sits between the sample mixer (or GPIO-chip sample override path) and the top-level DAC pins.

## Interface
- CHANNELS, 3, number of data lanes / samples per frame (>=1)
- SAMPLE_W, 12, bits per sample (>=2)
- CLK_DIV, 2, clk_i cycles per DAC clock half-period (>=1)

- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- sample_i  in  CHANNELS*SAMPLE_W  frame; channel c at [c*SAMPLE_W +: SAMPLE_W]
- sample_valid_i  in  1  one-cycle frame strobe
- invert_i  in  1  output (2^SAMPLE_W-1)-x instead of x
- mute_i  in  CHANNELS  per-channel force to midscale
- dac_clk_o  out  1  shared DAC bit clock
- dac_dat_o  out  CHANNELS  per-channel serial data
- dac_csb_o  out  1  chip select, active low
- dac_leb_o  out  1  latch enable, active low
- busy_o  out  1  frame in flight (state != IDLE)
- frame_done_o  out  1  one-cycle pulse at frame end
- overrun_o  out  1  one-cycle pulse: pending frame overwritten

## Operation
- Pending buffer: sample_valid_i high at edge N -> sample_i copied to pending, pending_flag=1.
- FSM states IDLE, SHIFT_LO, SHIFT_HI, LATCH; half-period counter div_cnt, bit counter bit_cnt.
- IDLE: if pending_flag -> load shift regs, clear pending_flag, csb low, go SHIFT_LO, bit_cnt=0.
- Load transform per channel c, evaluated at load edge: mute_i[c] -> 2^(SAMPLE_W-1) (no inversion); else invert_i ? (2^SAMPLE_W-1)-x : x. Width SAMPLE_W, no overflow possible.
- SHIFT_LO: dac_clk_o=0 for CLK_DIV cycles -> SHIFT_HI.
- SHIFT_HI: dac_clk_o=1 for CLK_DIV cycles; at exit, if bit_cnt==SAMPLE_W-1 -> LATCH (csb high, clk low), else shift left, bit_cnt++, -> SHIFT_LO.
- dac_dat_o[c] = shift_reg[c][SAMPLE_W-1]; changes only at the falling clock edge (entry to SHIFT_LO); stable across every rising edge.
- LATCH: dac_leb_o=0 for CLK_DIV cycles; at exit -> IDLE, frame_done_o=1 for that one cycle.
- Simultaneous: valid on the same edge as IDLE load -> current pending loaded to shifter, new frame becomes pending, no overrun.
- Valid while pending_flag=1 and not being consumed -> pending overwritten (newest wins), overrun_o pulses 1 cycle.
- Valid while IDLE and no pending -> frame waits in pending, load occurs next edge.

## Timing
- Reset values (all outputs, registered): dac_clk_o=0, dac_dat_o=0, dac_csb_o=1, dac_leb_o=1, busy_o=0, frame_done_o=0, overrun_o=0; pending_flag=0, FSM=IDLE.
- rst_i mid-frame: next edge forces reset values; partial frame and pending frame discarded; no frame_done_o.
- Latency: valid at edge N (idle, empty) -> csb low after edge N+1.
- csb low for 2*CLK_DIV*SAMPLE_W cycles; leb low CLK_DIV cycles immediately after csb rises; csb and leb never both low.
- Minimum frame period 2*CLK_DIV*SAMPLE_W + CLK_DIV + 1 cycles (one IDLE cycle between frames); defaults: 51 cycles.
- Back-to-back: frame pending at frame_done_o -> next csb low one cycle later.
- All outputs are flops; no combinational path from inputs to outputs.

## Test plan
- Defaults, sample_i={12'h000,12'hFFF,12'hA5C}, invert=0, mute=0 -> lane0 bits 1010_0101_1100, lane1 all 1, lane2 all 0; 12 rising clk edges; csb low 48 cycles; leb low 2 cycles; frame_done_o at cycle 51.
- invert_i=1, lane0=12'h001 -> lane0 shifts 12'hFFE; mute_i=3'b010 with lane1=12'h123 -> lane1 shifts 12'h800.
- Two valids 10 cycles apart during a frame, then third 5 cycles later -> overrun_o pulses once, second frame shifted after one IDLE cycle carries the third frame's data.
- Valid on exact cycle of IDLE load -> no overrun, both frames emitted consecutively, 51-cycle spacing of frame_done_o.
- rst_i asserted at bit 5 of a frame -> next cycle csb=1, leb=1, clk=0, busy=0; no frame_done_o; subsequent valid produces full clean frame.
- CHANNELS=1, SAMPLE_W=16, CLK_DIV=1 -> 16 bits, csb low 32 cycles, leb low 1 cycle, period 34.
